// File: rtl/interrupt_controller_pkg.sv
// Shared processor constants: interrupt FSM state encoding and interrupt controller defaults.
package interrupt_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_VECTOR,
    ST_SERVICE,
    ST_RETURN
  } int_state_t;

  localparam int unsigned DRAIN_CYCLES_DEF = 3;
  localparam logic [7:0]  ISR_VECTOR_DEF   = 8'hF0;

endpackage

// File: rtl/interrupt_controller_sync_edge.sv
// Two-flop synchronizer for the asynchronous interrupt line plus rising-edge detect.
module int_sync_edge (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
    end
  end

  assign o_rise = r_sync1 & ~r_sync2;

endmodule

// File: rtl/interrupt_controller.sv
// Single-level interrupt controller: drains the pipeline, vectors to the ISR and
// restores the saved PC on return-from-interrupt.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter logic [7:0]  ISR_VECTOR   = ISR_VECTOR_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       interrupt,
  input  logic       int_mask,
  input  logic [7:0] id_address,
  input  logic       reti_decoded,
  output logic       stall,
  output logic       flush_idex,
  output logic       flush_ifid,
  output logic       pc_load,
  output logic [7:0] pc_load_addr,
  output logic [7:0] epc,
  output logic       in_service,
  output logic       int_ack
);

  localparam logic [2:0] CNT_LOAD = 3'(DRAIN_CYCLES - 1);

  logic       w_edge;
  int_state_t r_state;
  logic       r_pending;
  logic [2:0] r_cnt;
  logic [7:0] r_epc;
  logic       r_stall;
  logic       r_flush_idex;
  logic       r_flush_ifid;
  logic       r_pc_load;
  logic [7:0] r_pc_load_addr;
  logic       r_in_service;
  logic       r_int_ack;

  int_sync_edge u_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_async (interrupt),
    .o_rise  (w_edge)
  );

  // Output registers are loaded with the decode of the state being entered,
  // so every output is a pure function of registered state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_pending      <= 1'b0;
      r_cnt          <= '0;
      r_epc          <= '0;
      r_stall        <= 1'b0;
      r_flush_idex   <= 1'b0;
      r_flush_ifid   <= 1'b0;
      r_pc_load      <= 1'b0;
      r_pc_load_addr <= '0;
      r_in_service   <= 1'b0;
      r_int_ack      <= 1'b0;
    end else begin
      if (r_state == ST_VECTOR) begin
        r_pending <= w_edge;
      end else if (w_edge) begin
        r_pending <= 1'b1;
      end

      r_stall        <= 1'b0;
      r_flush_idex   <= 1'b0;
      r_flush_ifid   <= 1'b0;
      r_pc_load      <= 1'b0;
      r_pc_load_addr <= '0;
      r_in_service   <= 1'b0;
      r_int_ack      <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (r_pending && !int_mask) begin
            r_state      <= ST_DRAIN;
            r_epc        <= id_address;
            r_cnt        <= CNT_LOAD;
            r_stall      <= 1'b1;
            r_flush_idex <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_cnt == '0) begin
            r_state        <= ST_VECTOR;
            r_pc_load      <= 1'b1;
            r_pc_load_addr <= ISR_VECTOR;
            r_flush_ifid   <= 1'b1;
            r_int_ack      <= 1'b1;
          end else begin
            r_cnt        <= r_cnt - 3'd1;
            r_stall      <= 1'b1;
            r_flush_idex <= 1'b1;
          end
        end
        ST_VECTOR: begin
          r_state      <= ST_SERVICE;
          r_in_service <= 1'b1;
        end
        ST_SERVICE: begin
          if (reti_decoded) begin
            r_state        <= ST_RETURN;
            r_pc_load      <= 1'b1;
            r_pc_load_addr <= r_epc;
            r_flush_ifid   <= 1'b1;
          end else begin
            r_in_service <= 1'b1;
          end
        end
        ST_RETURN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign stall        = r_stall;
  assign flush_idex   = r_flush_idex;
  assign flush_ifid   = r_flush_ifid;
  assign pc_load      = r_pc_load;
  assign pc_load_addr = r_pc_load_addr;
  assign epc          = r_epc;
  assign in_service   = r_in_service;
  assign int_ack      = r_int_ack;

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameters, one per line: DRAIN_CYCLES, 3, cycles allowed for EX/DM/WB to retire before vectoring.
REQ-002 ISR_VECTOR, 8'hF0, interrupt service routine start address.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 interrupt  input  1  external request, asynchronous to clk, active-high, edge-significant.
REQ-006 int_mask  input  1  high = a pending request is held but not taken.
REQ-007 id_address  input  8  address of the instruction currently in decode.
REQ-008 reti_decoded  input  1  decoder flag: return-from-interrupt is in decode.
REQ-009 stall  output  1  freezes PC and IF/ID register.
REQ-010 flush_idex  output  1  forces a bubble into ID/EX.
REQ-011 flush_ifid  output  1  forces a bubble into IF/ID.
REQ-012 pc_load  output  1  PC takes pc_load_addr next edge.
REQ-013 pc_load_addr  output  8  redirect target.
REQ-014 epc  output  8  saved return address.
REQ-015 in_service  output  1  high while ISR executes.
REQ-016 int_ack  output  1  one-cycle acknowledge pulse.

Function
REQ-017 interrupt SHALL pass a 2-flop synchronizer; rising edge = sync1 & ~sync2.
REQ-018 A detected edge SHALL set a one-deep pending flag; further edges while pending coalesce.
REQ-019 States: IDLE, DRAIN, VECTOR, SERVICE, RETURN; encoding one-hot or binary, implementer's choice.
REQ-020 IDLE -> DRAIN when pending & ~int_mask; epc <= id_address on that edge.
REQ-021 DRAIN: stall=1, flush_idex=1 for exactly DRAIN_CYCLES cycles (3-bit down-counter), then VECTOR.
REQ-022 VECTOR (1 cycle): pc_load=1, pc_load_addr=ISR_VECTOR, flush_ifid=1, int_ack=1, stall=0; pending cleared at exit edge unless a new edge arrives that same cycle (new edge wins).
REQ-023 SERVICE: in_service=1; all other controls 0; exit to RETURN when reti_decoded=1.
REQ-024 RETURN (1 cycle): pc_load=1, pc_load_addr=epc, flush_ifid=1, in_service=0; then IDLE.
REQ-025 No nesting: edges during DRAIN/VECTOR/SERVICE/RETURN set pending only; taken from IDLE afterwards (earliest one cycle after RETURN).
REQ-026 reti_decoded outside SERVICE SHALL be ignored.
REQ-027 int_mask only gates IDLE -> DRAIN; once DRAIN entered, sequence completes regardless of mask.
REQ-028 Latency: interrupt first sampled high at edge k -> pending=1 after k+1 -> DRAIN after k+2 -> VECTOR after k+2+DRAIN_CYCLES.
REQ-029 All outputs SHALL be registered-state decodes; pc_load_addr=8'h00 when pc_load=0.

Reset
REQ-030 reset at any edge (including mid-DRAIN/SERVICE) SHALL force IDLE, pending=0, synchronizer=0, counter=0, epc=8'h00, all outputs 0.
REQ-031 An interrupt edge coincident with reset SHALL be discarded.

Structure
REQ-032 State encoding, ISR_VECTOR and DRAIN_CYCLES defaults SHALL live in the shared processor constants package.
REQ-033 Synchronizer + edge detector SHALL be one sub-module, int_sync_edge; FSM, counter and epc stay in interrupt_controller.

Verification
REQ-034 Reset held 2 cycles, interrupt=0 -> all outputs 0, state IDLE, epc=8'h00.
REQ-035 id_address=8'h25, interrupt raised before edge 10 -> stall/flush_idex high cycles after edges 12-14, VECTOR after edge 15 with pc_load_addr=8'hF0, int_ack one pulse, epc=8'h25.
REQ-036 In SERVICE, reti_decoded=1 -> next cycle pc_load=1, pc_load_addr=8'h25, flush_ifid=1; then IDLE.
REQ-037 int_mask=1 then interrupt edge -> pending held, no stall; int_mask dropped -> DRAIN after next edge.
REQ-038 Second interrupt edge during SERVICE -> after RETURN, new DRAIN begins; three edges during SERVICE -> only one extra service.
REQ-039 reset asserted during 2nd DRAIN cycle -> next cycle all outputs 0, pending=0, no VECTOR occurs.
